// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory access controller: FSM state
// encoding, memory geometry and access-size encoding.
// -----------------------------------------------------------------------------
package dmem_pkg;

    localparam int unsigned MEM_DEPTH      = 32;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned BYTES_PER_WORD = 4;

    // Access size, as carried on the per-requester 'word' bit
    localparam logic SZ_BYTE = 1'b0;
    localparam logic SZ_WORD = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// -----------------------------------------------------------------------------
// dmem_access_ctrl_if
// Bundles the requester side (req/we/word/addr/wdata -> done/rdata/busy) and
// the byte-wide memory side (write strobe/address/data, read address/data)
// of the access controller.
//   slave  : the controller (consumes requests, drives the memory)
//   master : the environment (requesters plus the memory array)
// -----------------------------------------------------------------------------
interface dmem_access_ctrl_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREQ   = 2
);
    // requester side
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   we;
    logic [NREQ-1:0]   word;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic [NREQ-1:0]   done;
    logic [DATA_W-1:0] rdata;
    logic              busy;

    // memory side
    logic              mem_sw;
    logic [ADDR_W-1:0] mem_wr_add;
    logic [DATA_W-1:0] mem_wr_data;
    logic [ADDR_W-1:0] mem_rd_add;
    logic [DATA_W-1:0] mem_rd_data;

    modport slave (
        input  req, we, word, addr0, addr1, wdata0, wdata1, mem_rd_data,
        output done, rdata, busy, mem_sw, mem_wr_add, mem_wr_data, mem_rd_add
    );

    modport master (
        output req, we, word, addr0, addr1, wdata0, wdata1, mem_rd_data,
        input  done, rdata, busy, mem_sw, mem_wr_add, mem_wr_data, mem_rd_add
    );

endinterface

// File: rtl/dmem_access_ctrl_rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin arbiter.
//   clk, rst   : clock, asynchronous active-low reset
//   i_req      : request vector
//   i_advance  : a grant is being taken this cycle; rotate the pointer
//   o_gnt      : one-hot grant (combinational)
//   o_ptr      : registered pointer = requester favoured on the next tie
//                (reset 0, so requester 0 wins the first tie)
// -----------------------------------------------------------------------------
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    output logic [1:0] o_gnt,
    output logic       o_ptr
);

    logic r_ptr;

    always_comb begin
        o_gnt = '0;
        if (i_req == 2'b11) begin
            o_gnt[r_ptr] = 1'b1;
        end else begin
            o_gnt = i_req;
        end
    end

    // Favour the other requester after each grant: granting 0 points at 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= 1'b0;
        end else if (i_advance && (o_gnt != '0)) begin
            r_ptr <= o_gnt[0];
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_access_ctrl
// Arbitrates two requesters onto a byte-wide 32-entry data memory. Word
// accesses are split into four little-endian byte accesses with wrapping
// addresses; read bytes are reassembled into rdata and a one-cycle done pulse
// is returned to the granted requester.
//   clk  : clock
//   rst  : asynchronous active-low reset
//   bus  : dmem_access_ctrl_if.slave (requester and memory signals)
// -----------------------------------------------------------------------------
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREQ   = 2
) (
    input  logic              clk,
    input  logic              rst,
    dmem_access_ctrl_if.slave bus
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_cnt;
    logic              r_id;
    logic              r_we;
    logic              r_word;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;

    logic [NREQ-1:0]   w_gnt;
    logic              w_rr_ptr;
    logic              w_grant;
    logic              w_win_id;
    logic              w_last_byte;
    logic [ADDR_W-1:0] w_byte_addr;
    logic [BYTE_W-1:0] w_wr_byte;

    rr_arbiter2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .i_req     (bus.req),
        .i_advance (w_grant),
        .o_gnt     (w_gnt),
        .o_ptr     (w_rr_ptr)
    );

    assign w_grant  = (r_state == IDLE) && (w_gnt != '0);
    // On a tie the arbiter pointer names the winner; otherwise the lone requester.
    assign w_win_id = (bus.req == 2'b11) ? w_rr_ptr : w_gnt[1];

    assign w_last_byte = (r_word == SZ_WORD) ? (r_cnt == 2'(BYTES_PER_WORD - 1))
                                             : (r_cnt == 2'd0);
    // ADDR_W-bit sum wraps past the top of memory back to 0.
    assign w_byte_addr = r_addr + ADDR_W'(r_cnt);
    assign w_wr_byte   = r_wdata[BYTE_W*r_cnt +: BYTE_W];

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_grant)     w_state_nxt = XFER;
            XFER:    if (w_last_byte) w_state_nxt = DONE;
            DONE:                     w_state_nxt = IDLE;
            default:                  w_state_nxt = IDLE;
        endcase
    end

    // ---------------- request latch, byte counter, load reassembly ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_id    <= 1'b0;
            r_we    <= 1'b0;
            r_word  <= SZ_BYTE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (w_grant) begin
                r_id    <= w_win_id;
                r_we    <= bus.we[w_win_id];
                r_word  <= bus.word[w_win_id];
                r_addr  <= w_win_id ? bus.addr1  : bus.addr0;
                r_wdata <= w_win_id ? bus.wdata1 : bus.wdata0;
                r_cnt   <= '0;
            end else if (r_state == XFER) begin
                r_cnt <= r_cnt + 2'd1;
                if (!r_we) begin
                    // First byte clears the upper lanes so byte loads zero-extend.
                    if (r_cnt == 2'd0) begin
                        r_rdata <= {{(DATA_W-BYTE_W){1'b0}}, bus.mem_rd_data[BYTE_W-1:0]};
                    end else begin
                        r_rdata[BYTE_W*r_cnt +: BYTE_W] <= bus.mem_rd_data[BYTE_W-1:0];
                    end
                end
            end
        end
    end

    // ---------------- outputs, decoded from registers only ----------------
    always_comb begin
        bus.mem_sw      = 1'b0;
        bus.mem_wr_add  = '0;
        bus.mem_wr_data = '0;
        bus.mem_rd_add  = '0;
        bus.done        = '0;
        if (r_state == XFER) begin
            if (r_we) begin
                bus.mem_sw      = 1'b1;
                bus.mem_wr_add  = w_byte_addr;
                bus.mem_wr_data = {{(DATA_W-BYTE_W){1'b0}}, w_wr_byte};
            end else begin
                bus.mem_rd_add  = w_byte_addr;
            end
        end
        if (r_state == DONE) begin
            bus.done[r_id] = 1'b1;
        end
    end

    assign bus.busy  = (r_state != IDLE);
    assign bus.rdata = r_rdata;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_access_ctrl
// Bench for dmem_access_ctrl: a byte-wide memory array, a table of single
// accesses, and hand-written sequences for reset, contention and input
// stability. Expected memory writes and done/rdata events are queued when a
// request is driven and compared by a monitor when the DUT produces them.
// -----------------------------------------------------------------------------
module tb_dmem_access_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_access_ctrl_if #(.ADDR_W(5), .DATA_W(32), .NREQ(2)) bus ();

    dmem_access_ctrl #(.ADDR_W(5), .DATA_W(32), .NREQ(2)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- memory model ----------------
    logic [7:0] mem [32];
    logic       mem_clr;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
        end else if (bus.mem_sw) begin
            mem[bus.mem_wr_add] <= bus.mem_wr_data[7:0];
        end
    end

    assign bus.mem_rd_data = {24'h0, mem[bus.mem_rd_add]};

    // ---------------- scoreboard ----------------
    typedef struct {
        int          id;
        logic        we;
        logic        word;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        logic [4:0] a;
        logic [7:0] d;
    } wr_t;

    typedef struct {
        logic [1:0]  onehot;
        logic        ld;
        logic [31:0] r;
    } dn_t;

    wr_t wq[$];
    dn_t dq[$];
    int  total = 0;
    int  bad   = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        wr_t w;
        dn_t e;
        if (bus.mem_sw) begin
            if (wq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr %0d data %h expected no write",
                         bus.mem_wr_add, bus.mem_wr_data);
            end else begin
                w = wq.pop_front();
                chk("wr_addr", 32'(bus.mem_wr_add), 32'(w.a));
                chk("wr_data", bus.mem_wr_data, {24'h0, w.d});
            end
        end
        if (bus.done != 2'b00) begin
            if (dq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done %b expected none", bus.done);
            end else begin
                e = dq.pop_front();
                chk("done_id", 32'(bus.done), 32'(e.onehot));
                if (e.ld) chk("rdata", bus.rdata, e.r);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check_idle(input string tag);
        chk({tag, "_busy"},   32'(bus.busy),       32'h0);
        chk({tag, "_done"},   32'(bus.done),       32'h0);
        chk({tag, "_sw"},     32'(bus.mem_sw),     32'h0);
        chk({tag, "_wradd"},  32'(bus.mem_wr_add), 32'h0);
        chk({tag, "_wrdata"}, bus.mem_wr_data,     32'h0);
        chk({tag, "_rdadd"},  32'(bus.mem_rd_add), 32'h0);
        chk({tag, "_rdata"},  bus.rdata,           32'h0);
    endtask

    task automatic do_access(input vec_t v);
        int n;
        int cnt;
        bit seen;
        n = v.word ? 4 : 1;
        @(negedge clk);
        if (v.we) begin
            for (int i = 0; i < n; i++)
                wq.push_back('{a: v.addr + 5'(i), d: v.wdata[8*i +: 8]});
        end
        dq.push_back('{onehot: (v.id == 1) ? 2'b10 : 2'b01, ld: !v.we, r: v.rdata});
        bus.we[v.id]   = v.we;
        bus.word[v.id] = v.word;
        if (v.id == 0) begin
            bus.addr0  = v.addr;
            bus.wdata0 = v.wdata;
        end else begin
            bus.addr1  = v.addr;
            bus.wdata1 = v.wdata;
        end
        bus.req[v.id] = 1'b1;
        cnt  = 0;
        seen = 0;
        while (!seen && cnt < 20) begin
            @(negedge clk);
            cnt++;
            if (bus.done[v.id]) seen = 1;
        end
        bus.req[v.id] = 1'b0;
        // grant edge, then 1 or 4 XFER cycles, then DONE
        chk("latency", 32'(cnt), v.word ? 32'd5 : 32'd2);
        if (!v.we) begin
            @(negedge clk);
            chk("rdata_hold", bus.rdata, v.rdata);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        vec_t tbl [10];
        int   ndone;
        int   cnt;
        bit   seen;

        //            id we word addr   wdata          expected rdata
        tbl[0] = '{0, 1'b1, 1'b1, 5'd4,  32'hA1B2C3D4, 32'h0};
        tbl[1] = '{0, 1'b0, 1'b1, 5'd4,  32'h0,        32'hA1B2C3D4};
        tbl[2] = '{0, 1'b1, 1'b1, 5'd30, 32'h11223344, 32'h0};
        tbl[3] = '{0, 1'b0, 1'b0, 5'd0,  32'h0,        32'h00000022};
        tbl[4] = '{1, 1'b1, 1'b0, 5'd10, 32'hFFFFFF5A, 32'h0};
        tbl[5] = '{1, 1'b0, 1'b0, 5'd10, 32'h0,        32'h0000005A};
        tbl[6] = '{1, 1'b0, 1'b1, 5'd31, 32'h0,        32'h00112233};
        tbl[7] = '{0, 1'b1, 1'b1, 5'd1,  32'hDEADBEEF, 32'h0};
        tbl[8] = '{1, 1'b0, 1'b1, 5'd2,  32'h0,        32'hC3DEADBE};
        tbl[9] = '{0, 1'b0, 1'b0, 5'd7,  32'h0,        32'h000000A1};

        rst        = 1'b0;
        mem_clr    = 1'b1;
        bus.req    = 2'b00;
        bus.we     = 2'b00;
        bus.word   = 2'b00;
        bus.addr0  = '0;
        bus.addr1  = '0;
        bus.wdata0 = '0;
        bus.wdata1 = '0;
        repeat (2) @(negedge clk);
        check_idle("rst0");
        mem_clr = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        check_idle("post_rst");

        for (int k = 0; k < 10; k++) do_access(tbl[k]);

        // reset while idle: everything returns to zero and stays quiet
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_idle("rst_mid");
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_idle("idle_after");

        // reset in the middle of a word store to 8
        @(negedge clk);
        wq.push_back('{a: 5'd8, d: 8'h88});
        wq.push_back('{a: 5'd9, d: 8'h77});
        bus.we[0]   = 1'b1;
        bus.word[0] = 1'b1;
        bus.addr0   = 5'd8;
        bus.wdata0  = 32'h55667788;
        bus.req[0]  = 1'b1;
        @(negedge clk);
        chk("abort_b0_addr", 32'(bus.mem_wr_add), 32'd8);
        @(negedge clk);
        chk("abort_b1_addr", 32'(bus.mem_wr_add), 32'd9);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        bus.req = 2'b00;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'h0);
        chk("abort_sw", 32'(bus.mem_sw), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        chk("abort_release_busy", 32'(bus.busy), 32'h0);
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done != 2'b00) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        chk("abort_mem8", 32'(mem[8]), 32'h88);
        chk("abort_mem9", 32'(mem[9]), 32'h77);
        chk("abort_mem10", 32'(mem[10]), 32'h5A);
        chk("abort_mem11", 32'(mem[11]), 32'h00);

        // contention: both hold byte loads; grants alternate starting with 0
        @(negedge clk);
        for (int k = 0; k < 6; k++)
            dq.push_back('{onehot: (k % 2 == 1) ? 2'b10 : 2'b01, ld: 1'b1,
                           r: (k % 2 == 1) ? 32'h5A : 32'hDE});
        bus.we    = 2'b00;
        bus.word  = 2'b00;
        bus.addr0 = 5'd4;
        bus.addr1 = 5'd10;
        bus.req   = 2'b11;
        for (int k = 0; k < 6; k++) begin
            cnt  = 0;
            seen = 0;
            while (!seen && cnt < 20) begin
                @(negedge clk);
                cnt++;
                if (bus.done != 2'b00) seen = 1;
            end
            chk("cont_gnt", 32'(bus.done), (k % 2 == 1) ? 32'h2 : 32'h1);
            chk("cont_gap", 32'(cnt), (k == 0) ? 32'd2 : 32'd3);
        end
        bus.req = 2'b00;

        // stability: inputs change and req drops right after grant
        @(negedge clk);
        @(negedge clk);
        dq.push_back('{onehot: 2'b01, ld: 1'b1, r: 32'hADBEEF22});
        bus.we[0]   = 1'b0;
        bus.word[0] = 1'b1;
        bus.addr0   = 5'd0;
        bus.req[0]  = 1'b1;
        ndone = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stab_rd_add", 32'(bus.mem_rd_add), 32'(i));
            if (i == 0) begin
                bus.addr0   = 5'd20;
                bus.word[0] = 1'b0;
                bus.we[0]   = 1'b1;
                bus.req[0]  = 1'b0;
            end
        end
        repeat (6) begin
            @(negedge clk);
            if (bus.done[0]) ndone++;
        end
        chk("stab_done_count", 32'(ndone), 32'd1);

        repeat (2) @(negedge clk);
        chk("wq_drained", 32'(wq.size()), 32'd0);
        chk("dq_drained", 32'(dq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
